paint_pixel_gen: RTL and testbench

PAINT_PIXEL_GEN -- requirements
Module: paint_pixel_gen

---
 rtl/paint_pixel_gen.sv | 141 ++++++++++++++
 tb/tb_paint_pixel_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/paint_pixel_gen.sv
// Paint canvas pixel colour and 8x8 cursor generator; CURSOR_BLINK_EN adds 16-frame cursor blink.
// Latency: RGB 1 clk after x_in/y_in; cursor moves only at frame start; no backpressure.
module paint_pixel_gen #(
    parameter logic [3:0] BG_R      = 4'd0,
    parameter logic [3:0] BG_G      = 4'd0,
    parameter logic [3:0] BG_B      = 4'd8,
    parameter int         FAST_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       fast,
    output logic [3:0] R,
    output logic [3:0] G,
    output logic [3:0] B,
    output logic [9:0] cur_x,
    output logic [8:0] cur_y,
    output logic       frame_tick
);

    localparam logic [10:0] MAX_X = 11'd632;
    localparam logic [9:0]  MAX_Y = 10'd472;

    logic [3:0]  r_r, r_g, r_b;
    logic [9:0]  r_cur_x;
    logic [8:0]  r_cur_y;
    logic        r_frame_tick;

    logic        w_frame_start;
    logic        w_visible;
    logic [9:0]  w_px;
    logic [8:0]  w_py;
    logic        w_border;
    logic        w_on_cursor;
    logic        w_cursor_en;
    logic [10:0] w_step_x;
    logic [9:0]  w_step_y;
    logic [10:0] w_x_dec, w_x_inc;
    logic [9:0]  w_y_dec, w_y_inc;
    logic [9:0]  w_next_x;
    logic [8:0]  w_next_y;
    logic [3:0]  w_r, w_g, w_b;

    assign w_frame_start = (x_in == 10'd0) && (y_in == 9'd0);
    assign w_visible     = (x_in >= 10'd64) && (x_in <= 10'd703) &&
                           (y_in >= 9'd16)  && (y_in <= 9'd495);
    assign w_px          = x_in - 10'd64;
    assign w_py          = y_in - 9'd16;
    assign w_border      = (w_px == 10'd0) || (w_px == 10'd639) ||
                           (w_py == 9'd0)  || (w_py == 9'd479);
    assign w_on_cursor   = (w_px >= r_cur_x) && ({1'b0, w_px} <= {1'b0, r_cur_x} + 11'd7) &&
                           (w_py >= r_cur_y) && ({1'b0, w_py} <= {1'b0, r_cur_y} + 10'd7);

`ifdef CURSOR_BLINK_EN
    logic [4:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_frame_cnt <= 5'd0;
        else if (w_frame_start)
            r_frame_cnt <= r_frame_cnt + 5'd1;
    end

    assign w_cursor_en = ~r_frame_cnt[4];
`else
    assign w_cursor_en = 1'b1;
`endif

    // One extra bit on each side of the clamp exposes borrow/carry past the limits.
    assign w_step_x = fast ? 11'(FAST_STEP) : 11'd1;
    assign w_step_y = fast ? 10'(FAST_STEP) : 10'd1;
    assign w_x_dec  = {1'b0, r_cur_x} - w_step_x;
    assign w_x_inc  = {1'b0, r_cur_x} + w_step_x;
    assign w_y_dec  = {1'b0, r_cur_y} - w_step_y;
    assign w_y_inc  = {1'b0, r_cur_y} + w_step_y;

    always_comb begin
        w_next_x = r_cur_x;
        w_next_y = r_cur_y;
        if (btn_left && !btn_right)
            w_next_x = w_x_dec[10] ? 10'd0 : w_x_dec[9:0];
        else if (btn_right && !btn_left)
            w_next_x = (w_x_inc > MAX_X) ? MAX_X[9:0] : w_x_inc[9:0];
        if (btn_up && !btn_down)
            w_next_y = w_y_dec[9] ? 9'd0 : w_y_dec[8:0];
        else if (btn_down && !btn_up)
            w_next_y = (w_y_inc > MAX_Y) ? MAX_Y[8:0] : w_y_inc[8:0];
    end

    always_comb begin
        w_r = 4'd0;
        w_g = 4'd0;
        w_b = 4'd0;
        if (w_visible) begin
            if (w_on_cursor && w_cursor_en) begin
                w_r = 4'hF;
            end else if (w_border) begin
                w_r = 4'hF;
                w_g = 4'hF;
                w_b = 4'hF;
            end else begin
                w_r = BG_R;
                w_g = BG_G;
                w_b = BG_B;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r          <= 4'd0;
            r_g          <= 4'd0;
            r_b          <= 4'd0;
            r_cur_x      <= 10'd0;
            r_cur_y      <= 9'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_r          <= w_r;
            r_g          <= w_g;
            r_b          <= w_b;
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                r_cur_x <= w_next_x;
                r_cur_y <= w_next_y;
            end
        end
    end

    assign R          = r_r;
    assign G          = r_g;
    assign B          = r_b;
    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_paint_pixel_gen.sv
// Bench for paint_pixel_gen: directed vectors, cursor clamp/reset sequences, and random pixels vs an integer model.
module tb_paint_pixel_gen;

    localparam logic [3:0] BG_R      = 4'd0;
    localparam logic [3:0] BG_G      = 4'd0;
    localparam logic [3:0] BG_B      = 4'd8;
    localparam int         FAST_STEP = 4;
    localparam logic [11:0] BG_RGB   = {BG_R, BG_G, BG_B};

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_in;
    logic [8:0] y_in;
    logic       btn_left, btn_right, btn_up, btn_down, fast;
    logic [3:0] R, G, B;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic       frame_tick;

    always #5 clk = ~clk;

    paint_pixel_gen #(
        .BG_R(BG_R), .BG_G(BG_G), .BG_B(BG_B), .FAST_STEP(FAST_STEP)
    ) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .fast(fast), .R(R), .G(G), .B(B), .cur_x(cur_x), .cur_y(cur_y),
        .frame_tick(frame_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cursor position and frames seen since reset.
    int m_cx, m_cy, m_frames;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y, input int cx,
                                              input int cy, input int frames);
        int  px, py;
        bit  shown;
        if (x < 64 || x > 703 || y < 16 || y > 495) return 12'h000;
        px = x - 64;
        py = y - 16;
`ifdef CURSOR_BLINK_EN
        shown = ((frames % 32) < 16);
`else
        shown = (frames >= 0);
`endif
        if (shown && px >= cx && px <= cx + 7 && py >= cy && py <= cy + 7) return 12'hF00;
        if (px == 0 || px == 639 || py == 0 || py == 479) return 12'hFFF;
        return BG_RGB;
    endfunction

    // Drives one pixel for one clock, then checks against the model just after the edge.
    task automatic step(input int x, input int y, input logic l, input logic r,
                        input logic u, input logic d, input logic f, input string tag);
        logic [11:0] exp_rgb;
        bit          fs;
        int          stp, dx, dy;
        x_in = 10'(x); y_in = 9'(y);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; fast = f;
        @(posedge clk);
        #1;
        exp_rgb = model_rgb(x, y, m_cx, m_cy, m_frames);
        fs      = (x == 0 && y == 0);
        if (fs) begin
            stp  = f ? FAST_STEP : 1;
            dx   = (r && !l) ? stp : ((l && !r) ? -stp : 0);
            dy   = (d && !u) ? stp : ((u && !d) ? -stp : 0);
            m_cx = clampi(m_cx + dx, 0, 632);
            m_cy = clampi(m_cy + dy, 0, 472);
            m_frames++;
        end
        check({tag, "_rgb"},   {R, G, B},  exp_rgb);
        check({tag, "_tick"},  frame_tick, 32'(fs));
        check({tag, "_cur_x"}, cur_x,      m_cx);
        check({tag, "_cur_y"}, cur_y,      m_cy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x_in = 10'd300; y_in = 9'd200;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; fast = 0;
        @(posedge clk);
        #1;
        check("rst_rgb",   {R, G, B},  12'h000);
        check("rst_cur_x", cur_x,      0);
        check("rst_cur_y", cur_y,      0);
        check("rst_tick",  frame_tick, 0);
        rst = 1'b0;
        m_cx = 0; m_cy = 0; m_frames = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic l, r, u, d, f;
        int   x, y;

        vecs[0]  = '{64,  16,  12'hF00};
        vecs[1]  = '{700, 200, BG_RGB};
        vecs[2]  = '{10,  200, 12'h000};
        vecs[3]  = '{71,  23,  12'hF00};
        vecs[4]  = '{72,  16,  12'hFFF};
        vecs[5]  = '{64,  24,  12'hFFF};
        vecs[6]  = '{703, 495, 12'hFFF};
        vecs[7]  = '{704, 200, 12'h000};
        vecs[8]  = '{100, 496, 12'h000};
        vecs[9]  = '{300, 200, BG_RGB};
        vecs[10] = '{63,  16,  12'h000};
        vecs[11] = '{72,  24,  BG_RGB};

        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].x, vecs[i].y, 0, 0, 0, 0, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), {R, G, B}, vecs[i].rgb);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 1, "fast_right");
        check("cur_x_after_3_fast", cur_x, 12);
        step(0, 0, 1, 1, 0, 0, 1, "left_and_right");
        check("cur_x_lr_hold", cur_x, 12);
        step(76, 16, 0, 0, 0, 0, 0, "cursor_left_edge");
        check("cursor_pixel_12", {R, G, B}, 12'hF00);
        step(75, 16, 0, 0, 0, 0, 0, "left_of_cursor");
        check("border_left_of_cursor", {R, G, B}, 12'hFFF);

        // Mid-frame button changes must not move the cursor.
        step(300, 200, 0, 1, 0, 1, 1, "btn_midframe");
        check("midframe_no_move", cur_x, 12);

        for (int i = 0; i < 154; i++) step(0, 0, 0, 1, 0, 0, 1, "walk_right");
        step(0, 0, 0, 1, 0, 0, 0, "slow_right");
        step(0, 0, 0, 1, 0, 0, 0, "slow_right");
        check("cur_x_630", cur_x, 630);
        step(0, 0, 0, 1, 0, 0, 1, "clamp_right");
        check("cur_x_clamp_632", cur_x, 632);
        step(0, 0, 0, 1, 0, 0, 1, "clamp_right_hold");
        check("cur_x_stays_632", cur_x, 632);
        step(0, 0, 0, 0, 1, 0, 1, "clamp_up");
        check("cur_y_stays_0", cur_y, 0);
        for (int i = 0; i < 120; i++) step(0, 0, 0, 0, 0, 1, 1, "walk_down");
        check("cur_y_clamp_472", cur_y, 472);
        step(703, 495, 0, 0, 0, 0, 0, "cursor_corner");
        check("cursor_over_corner", {R, G, B}, 12'hF00);

        // Asynchronous reset mid-frame while frame_tick is high.
        do_reset();
        for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 0, 0, 1, "to_100");
        check("cur_x_100", cur_x, 100);
        check("tick_before_rst", frame_tick, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rgb",   {R, G, B},  12'h000);
        check("async_rst_cur_x", cur_x,      0);
        check("async_rst_tick",  frame_tick, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cx = 0; m_cy = 0; m_frames = 0;
        step(0, 0, 0, 1, 0, 0, 0, "first_move_after_rst");
        check("cur_x_after_rst_move", cur_x, 1);

        // Random pixels and buttons, biased toward the cursor neighbourhood.
        l = 0; r = 0; u = 0; d = 0; f = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                l = 1'($urandom); r = 1'($urandom); u = 1'($urandom);
                d = 1'($urandom); f = 1'($urandom);
            end
            case ($urandom_range(0, 7))
                0: begin x = 0; y = 0; end
                1, 2: begin
                    x = 63 + m_cx + int'($urandom_range(0, 9));
                    y = 15 + m_cy + int'($urandom_range(0, 9));
                end
                default: begin
                    x = int'($urandom_range(0, 767));
                    y = int'($urandom_range(0, 511));
                end
            endcase
            step(x, y, l, r, u, d, f, "rand");
        end

`ifdef CURSOR_BLINK_EN
        do_reset();
        for (int k = 0; k <= 32; k++) begin
            step(64, 16, 0, 0, 0, 0, 0, $sformatf("blink_f%0d", k));
            check($sformatf("blink_frame%0d", k), {R, G, B},
                  (k < 16 || k == 32) ? 12'hF00 : 12'hFFF);
            step(300, 200, 0, 0, 0, 0, 0, $sformatf("blink_bg%0d", k));
            step(0, 0, 0, 0, 0, 0, 0, "blink_frame_start");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
